// File: rtl/tt_spine_ctrl.sv
// tt_spine_ctrl: break-before-make select/enable sequencer for the spine plus the pad<->spine bridge.
// Build option TT_SPINE_CTRL_SAT_EN: address saturates at 511 instead of wrapping to 0.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_OFF    | spine disabled, pending address requests commit freely
//   ST_SETTLE | enable requested, select held stable while timer counts down
//   ST_ACTIVE | spine enabled, address frozen
//   ST_DROP   | single enable-low cycle, pending requests commit here
module tt_spine_ctrl #(
    parameter int N_O         = 8,
    parameter int N_I         = 10,
    parameter int N_IO        = 8,
    parameter int SETTLE_CYC  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ctrl_sel_rst,
    input  logic                      ctrl_sel_inc,
    input  logic                      ctrl_ena,
    input  logic [N_I-1:0]            pad_ui_in,
    input  logic [N_IO-1:0]           pad_uio_in,
    output logic [N_O-1:0]            pad_uo_out,
    output logic [N_IO-1:0]           pad_uio_out,
    output logic [N_IO-1:0]           pad_uio_oe,
    input  logic [N_O+2*N_IO+1:0]     spine_ow,
    output logic [N_I+N_IO+11:0]      spine_iw,
    output logic [8:0]                sel_cur,
    output logic                      active
);

    localparam int USR_OW = N_O + 2*N_IO;
    localparam int USR_IW = N_I + N_IO;
    localparam int CNT_W  = $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {ST_OFF, ST_SETTLE, ST_ACTIVE, ST_DROP} state_t;

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         cnt, cnt_nxt;
    logic [SYNC_STAGES-1:0]   rst_sync, inc_sync, ena_sync;
    logic                     rst_s, inc_s, ena_s, inc_d, inc_edge;
    logic                     pend_clr, pend_clr_nxt;
    logic [1:0]               pend_inc, pend_inc_nxt;
    logic                     pend_any, commit;
    logic [8:0]               sel_nxt;
    logic                     ena_q, ena_nxt;
    logic [USR_IW-1:0]        usr_in_q, usr_in_nxt;
    logic [USR_OW-1:0]        usr_out_q, usr_out_nxt;
    logic                     guards_unused;

    assign rst_s    = rst_sync[SYNC_STAGES-1];
    assign inc_s    = inc_sync[SYNC_STAGES-1];
    assign ena_s    = ena_sync[SYNC_STAGES-1];
    assign inc_edge = inc_s & ~inc_d;
    assign pend_any = pend_clr | (pend_inc != 2'd0);
    // The address is frozen for the whole enabled window.
    assign commit   = pend_any & (state != ST_ACTIVE);

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_sync  <= '0;
            inc_sync  <= '0;
            ena_sync  <= '0;
            inc_d     <= 1'b0;
            pend_clr  <= 1'b0;
            pend_inc  <= 2'd0;
            sel_cur   <= 9'd0;
            state     <= ST_OFF;
            cnt       <= '0;
            ena_q     <= 1'b0;
            usr_in_q  <= '0;
            usr_out_q <= '0;
        end else begin
            rst_sync  <= {rst_sync[SYNC_STAGES-2:0], ctrl_sel_rst};
            inc_sync  <= {inc_sync[SYNC_STAGES-2:0], ctrl_sel_inc};
            ena_sync  <= {ena_sync[SYNC_STAGES-2:0], ctrl_ena};
            inc_d     <= inc_s;
            pend_clr  <= pend_clr_nxt;
            pend_inc  <= pend_inc_nxt;
            sel_cur   <= sel_nxt;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            ena_q     <= ena_nxt;
            usr_in_q  <= usr_in_nxt;
            usr_out_q <= usr_out_nxt;
        end
    end

`ifdef TT_SPINE_CTRL_SAT_EN
    logic [9:0] sel_sum;
    assign sel_sum = {1'b0, sel_cur} + {8'd0, pend_inc};
`endif

    always_comb begin
        pend_clr_nxt = commit ? 1'b0 : pend_clr;
        pend_inc_nxt = commit ? 2'd0 : pend_inc;
        // A clear wins over any increment, pending or arriving.
        if (rst_s) begin
            pend_clr_nxt = 1'b1;
            pend_inc_nxt = 2'd0;
        end else if (inc_edge && !pend_clr_nxt && pend_inc_nxt != 2'd3) begin
            pend_inc_nxt = pend_inc_nxt + 2'd1;
        end

        sel_nxt = sel_cur;
        if (commit) begin
            if (pend_clr) begin
                sel_nxt = 9'd0;
            end else begin
`ifdef TT_SPINE_CTRL_SAT_EN
                sel_nxt = sel_sum[9] ? 9'h1FF : sel_sum[8:0];
`else
                sel_nxt = sel_cur + 9'(pend_inc);
`endif
            end
        end

        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_OFF: begin
                if (ena_s && !rst_s) begin
                    state_nxt = ST_SETTLE;
                    cnt_nxt   = CNT_W'(SETTLE_CYC);
                end
            end
            ST_SETTLE: begin
                if (!ena_s) begin
                    state_nxt = ST_OFF;
                end else if (commit) begin
                    cnt_nxt = CNT_W'(SETTLE_CYC);
                end else if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_ACTIVE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (pend_any || !ena_s) state_nxt = ST_DROP;
            end
            ST_DROP: begin
                if (ena_s && !rst_s) begin
                    state_nxt = ST_SETTLE;
                    cnt_nxt   = CNT_W'(SETTLE_CYC);
                end else begin
                    state_nxt = ST_OFF;
                end
            end
            default: state_nxt = ST_OFF;
        endcase
    end

    // Data registers load only for a cycle that will be ACTIVE, so they read 0 otherwise.
    always_comb begin
        ena_nxt     = (state_nxt == ST_ACTIVE);
        usr_in_nxt  = ena_nxt ? {pad_uio_in, pad_ui_in} : '0;
        usr_out_nxt = ena_nxt ? spine_ow[USR_OW:1] : '0;
    end

    assign guards_unused = spine_ow[USR_OW+1] ^ spine_ow[0];

    assign active      = ena_q;
    assign spine_iw    = {1'b0, usr_in_q, sel_cur, ena_q, 1'b0};
    assign pad_uo_out  = usr_out_q[N_O-1:0];
    assign pad_uio_out = usr_out_q[N_O+N_IO-1:N_O];
    assign pad_uio_oe  = usr_out_q[USR_OW-1:N_O+N_IO];

endmodule

// File: tb/tb_tt_spine_ctrl.sv
// Bench for tt_spine_ctrl: directed scenarios plus random pin/data activity against a cycle model.
module tb_tt_spine_ctrl;

    localparam int N_O = 8, N_I = 10, N_IO = 8, SC = 4, SS = 2;
    localparam int OW = N_O + 2*N_IO + 2;
    localparam int IW = N_I + N_IO + 12;
    localparam int M_OFF = 0, M_SETTLE = 1, M_ACTIVE = 2, M_DROP = 3;

    logic            clk = 1'b0, rst = 1'b1;
    logic            ctrl_sel_rst = 1'b0, ctrl_sel_inc = 1'b0, ctrl_ena = 1'b0;
    logic [N_I-1:0]  pad_ui_in = '0;
    logic [N_IO-1:0] pad_uio_in = '0;
    logic [N_O-1:0]  pad_uo_out;
    logic [N_IO-1:0] pad_uio_out, pad_uio_oe;
    logic [OW-1:0]   spine_ow = '0;
    logic [IW-1:0]   spine_iw;
    logic [8:0]      sel_cur;
    logic            active;

    int errors = 0, checks = 0;
    bit chk_en = 0, rand_data = 1;

    always #5 clk = ~clk;

    tt_spine_ctrl #(.N_O(N_O), .N_I(N_I), .N_IO(N_IO), .SETTLE_CYC(SC), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .ctrl_sel_rst(ctrl_sel_rst), .ctrl_sel_inc(ctrl_sel_inc),
        .ctrl_ena(ctrl_ena), .pad_ui_in(pad_ui_in), .pad_uio_in(pad_uio_in),
        .pad_uo_out(pad_uo_out), .pad_uio_out(pad_uio_out), .pad_uio_oe(pad_uio_oe),
        .spine_ow(spine_ow), .spine_iw(spine_iw), .sel_cur(sel_cur), .active(active));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pins seen through SS-deep delay lines, requests as counts, phases by name.
    bit [SS-1:0] h_rst, h_inc, h_ena;
    bit          m_incd, m_pclr, m_act;
    int          m_pinc, m_sel, m_mode, m_cnt;
    logic [N_I+N_IO-1:0]  m_usr_in;
    logic [N_O+2*N_IO-1:0] m_usr_out;
    bit          rst_at_edge;

    always @(posedge clk) begin : model
        bit rs, is, es, rise, pend, commit;
        int nsel, npinc, nmode, ncnt;
        bit npclr;
        rst_at_edge <= rst;
        if (rst) begin
            h_rst = '0; h_inc = '0; h_ena = '0; m_incd = 0; m_pclr = 0; m_pinc = 0;
            m_sel = 0; m_mode = M_OFF; m_cnt = 0; m_act = 0; m_usr_in = '0; m_usr_out = '0;
        end else begin
            rs = h_rst[SS-1]; is = h_inc[SS-1]; es = h_ena[SS-1];
            rise = is && !m_incd;
            pend = m_pclr || (m_pinc > 0);
            commit = pend && (m_mode != M_ACTIVE);
            nsel = m_sel;
            if (commit) begin
                if (m_pclr) nsel = 0;
`ifdef TT_SPINE_CTRL_SAT_EN
                else nsel = (m_sel + m_pinc > 511) ? 511 : m_sel + m_pinc;
`else
                else nsel = (m_sel + m_pinc) % 512;
`endif
            end
            npclr = commit ? 0 : m_pclr;
            npinc = commit ? 0 : m_pinc;
            if (rs) begin npclr = 1; npinc = 0; end
            else if (rise && !npclr) npinc = (npinc + 1 > 3) ? 3 : npinc + 1;
            nmode = m_mode; ncnt = m_cnt;
            case (m_mode)
                M_OFF:    if (es && !rs) begin nmode = M_SETTLE; ncnt = SC; end
                M_SETTLE: if (!es) nmode = M_OFF;
                          else if (commit) ncnt = SC;
                          else begin ncnt = m_cnt - 1; if (ncnt == 0) nmode = M_ACTIVE; end
                M_ACTIVE: if (pend || !es) nmode = M_DROP;
                default:  if (es && !rs) begin nmode = M_SETTLE; ncnt = SC; end
                          else nmode = M_OFF;
            endcase
            m_sel = nsel; m_pclr = npclr; m_pinc = npinc; m_mode = nmode; m_cnt = ncnt;
            m_act = (nmode == M_ACTIVE);
            m_usr_in  = m_act ? {pad_uio_in, pad_ui_in} : '0;
            m_usr_out = m_act ? spine_ow[OW-2:1] : '0;
            m_incd = is;
            h_rst = {h_rst[SS-2:0], ctrl_sel_rst};
            h_inc = {h_inc[SS-2:0], ctrl_sel_inc};
            h_ena = {h_ena[SS-2:0], ctrl_ena};
        end
    end

    logic [8:0] prev_sel;
    bit         prev_act;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("sel_cur", 64'(sel_cur), 64'(m_sel));
            chk("active", 64'(active), 64'(m_act));
            chk("spine_iw", 64'(spine_iw), 64'({1'b0, m_usr_in, 9'(m_sel), m_act, 1'b0}));
            chk("pad_uo_out", 64'(pad_uo_out), 64'(m_usr_out[7:0]));
            chk("pad_uio_out", 64'(pad_uio_out), 64'(m_usr_out[15:8]));
            chk("pad_uio_oe", 64'(pad_uio_oe), 64'(m_usr_out[23:16]));
            if (sel_cur !== prev_sel && !rst_at_edge)
                chk("sel_change_while_ena", 64'({active, prev_act}), 64'd0);
        end
        prev_sel = sel_cur;
        prev_act = active;
    end

    always @(negedge clk) begin
        if (rand_data) begin
            pad_ui_in  = N_I'($urandom);
            pad_uio_in = N_IO'($urandom);
            spine_ow   = OW'($urandom);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_inc();
        ctrl_sel_inc = 1'b1; cyc(1);
        ctrl_sel_inc = 1'b0; cyc(1);
    endtask

    task automatic pulse_clr();
        ctrl_sel_rst = 1'b1; cyc(1);
        ctrl_sel_rst = 1'b0; cyc(6);
    endtask

    task automatic wait_act(input logic v, input int budget, output int n);
        n = 0;
        while (active !== v && n < budget) begin cyc(1); n++; end
        chk("wait_active", 64'(active), 64'(v));
    endtask

    initial begin
        int n, r;
        cyc(1);
        chk_en = 1;
        cyc(2);
        rst = 1'b0;
        cyc(20);
        chk("idle_sel", 64'(sel_cur), 64'd0);
        chk("idle_active", 64'(active), 64'd0);
        chk("idle_iw", 64'(spine_iw), 64'd0);
        chk("idle_pads", 64'({pad_uo_out, pad_uio_out, pad_uio_oe}), 64'd0);

        repeat (5) pulse_inc();
        cyc(8);
        ctrl_ena = 1'b1;
        wait_act(1'b1, 30, n);
        chk("ena_latency", 64'(n), 64'(SS + 1 + SC));
        chk("sel5", 64'(sel_cur), 64'd5);
        chk("iw_sel5", 64'(spine_iw[10:2]), 64'd5);
        chk("iw_ena", 64'(spine_iw[1]), 64'd1);

        pulse_inc();
        wait_act(1'b0, 20, n);
        chk("drop_sel_held", 64'(sel_cur), 64'd5);
        wait_act(1'b1, 20, n);
        chk("ena_low_cycles", 64'(n), 64'(SC + 1));
        chk("sel6", 64'(sel_cur), 64'd6);

        rand_data = 0;
        spine_ow = {1'b1, 24'h00A55A, 1'b1};
        pad_ui_in = 10'h2C3;
        pad_uio_in = 8'h00;
        cyc(1);
        chk("uo_5a", 64'(pad_uo_out), 64'h5A);
        chk("uio_a5", 64'(pad_uio_out), 64'hA5);
        chk("oe_00", 64'(pad_uio_oe), 64'h00);
        chk("iw_ui_2c3", 64'(spine_iw[20:11]), 64'h2C3);
        ctrl_ena = 1'b0;
        wait_act(1'b0, 20, n);
        chk("pads_off", 64'({pad_uo_out, pad_uio_out, pad_uio_oe}), 64'd0);
        chk("iw_usr_off", 64'(spine_iw[28:11]), 64'd0);
        rand_data = 1;

        pulse_clr();
        chk("cleared", 64'(sel_cur), 64'd0);
        repeat (511) pulse_inc();
        cyc(6);
        chk("sel511", 64'(sel_cur), 64'd511);
        pulse_inc();
        cyc(6);
`ifdef TT_SPINE_CTRL_SAT_EN
        chk("sel_top", 64'(sel_cur), 64'd511);
`else
        chk("sel_top", 64'(sel_cur), 64'd0);
`endif

        pulse_clr();
        repeat (9) pulse_inc();
        cyc(6);
        ctrl_ena = 1'b1;
        wait_act(1'b1, 30, n);
        chk("sel9", 64'(sel_cur), 64'd9);
        ctrl_sel_rst = 1'b1; ctrl_sel_inc = 1'b1;
        cyc(2);
        ctrl_sel_rst = 1'b0; ctrl_sel_inc = 1'b0;
        wait_act(1'b0, 20, n);
        wait_act(1'b1, 40, n);
        chk("clr_beats_inc", 64'(sel_cur), 64'd0);

        repeat (2) pulse_inc();
        wait_act(1'b0, 20, n);
        wait_act(1'b1, 40, n);
        chk("sel2", 64'(sel_cur), 64'd2);
        rst = 1'b1;
        cyc(1);
        chk("rst_active", 64'(active), 64'd0);
        chk("rst_sel", 64'(sel_cur), 64'd0);
        chk("rst_iw", 64'(spine_iw), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 6) ctrl_sel_inc = ~ctrl_sel_inc;
            else if (r < 9) ctrl_ena = ~ctrl_ena;
            ctrl_sel_rst = ($urandom_range(0, 99) < 2);
            rst = ($urandom_range(0, 999) < 3);
            cyc(1);
        end
        rst = 1'b0;
        cyc(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
